// File: rtl/issue_scoreboard_n.sv
// issue_scoreboard_n
// Dual-issue decode/execute scoreboard with per-register pending-write
// counters. Decides in the same cycle whether slot 0 and slot 1 of the
// decode bundle may issue, and drives the fetch/decode stall controls.
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-low reset
//   flush_i                kill the decode bundle this cycle
//   d0_*_i, d1_*_i         slot 0 / slot 1 fields (slot 1 is younger)
//   wb_en_i, wb_rd_i       write-back ports releasing pending writes
//   issue0_o, issue1_o     slot accepted into execute (combinational)
//   stall_F_o, stall_D_o   hold PC / hold whole decode bundle
//   split_D_o              slot 0 issued, slot 1 shifts down
//   stall_cycles_o         saturating count of decode stall cycles
//   underflow_err_o        sticky write-back-without-pending error
module issue_scoreboard_n #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int WB_PORTS = 2,
  parameter int CNT_W    = 2,
  parameter int STALL_W  = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       d0_valid_i,
  input  logic [REG_AW-1:0]          d0_rs1_i,
  input  logic [REG_AW-1:0]          d0_rs2_i,
  input  logic [REG_AW-1:0]          d0_rd_i,
  input  logic                       d0_rs1_en_i,
  input  logic                       d0_rs2_en_i,
  input  logic                       d0_writes_i,
  input  logic                       d1_valid_i,
  input  logic [REG_AW-1:0]          d1_rs1_i,
  input  logic [REG_AW-1:0]          d1_rs2_i,
  input  logic [REG_AW-1:0]          d1_rd_i,
  input  logic                       d1_rs1_en_i,
  input  logic                       d1_rs2_en_i,
  input  logic                       d1_writes_i,
  input  logic [WB_PORTS-1:0]        wb_en_i,
  input  logic [WB_PORTS*REG_AW-1:0] wb_rd_i,
  output logic                       issue0_o,
  output logic                       issue1_o,
  output logic                       stall_F_o,
  output logic                       stall_D_o,
  output logic                       split_D_o,
  output logic [STALL_W-1:0]         stall_cycles_o,
  output logic                       underflow_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  // Wide enough for cnt + 1 and for a decrement of up to WB_PORTS.
  localparam int SUM_W = CNT_W + $clog2(WB_PORTS + 1) + 1;

  logic [CNT_W-1:0]   cnt_q [NUM_REGS];
  logic [CNT_W-1:0]   cnt_d [NUM_REGS];
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               uf_q, uf_d;

  logic               hz0, hz1, intra;
  logic               inc;
  logic [SUM_W-1:0]   sum, dec;

  // Register 0 and addresses beyond NUM_REGS read as never pending.
  function automatic logic [CNT_W-1:0] cnt_at(input logic [REG_AW-1:0] a);
    if (a == '0 || 32'(a) >= NUM_REGS) return '0;
    return cnt_q[a];
  endfunction

  function automatic logic busy(input logic [REG_AW-1:0] a);
    return cnt_at(a) != '0;
  endfunction

  always_comb begin
    hz0 = (d0_rs1_en_i && busy(d0_rs1_i)) ||
          (d0_rs2_en_i && busy(d0_rs2_i)) ||
          (d0_writes_i && d0_rd_i != '0 && cnt_at(d0_rd_i) == CNT_MAX);
    // Slot 1 may not read or rewrite what slot 0 writes in the same bundle.
    intra = d0_writes_i && d0_rd_i != '0 &&
            ((d1_rs1_en_i && d1_rs1_i == d0_rd_i) ||
             (d1_rs2_en_i && d1_rs2_i == d0_rd_i) ||
             (d1_writes_i && d1_rd_i  == d0_rd_i));
    hz1 = (d1_rs1_en_i && busy(d1_rs1_i)) ||
          (d1_rs2_en_i && busy(d1_rs2_i)) ||
          (d1_writes_i && d1_rd_i != '0 && cnt_at(d1_rd_i) == CNT_MAX) ||
          intra;
  end

  assign issue0_o  = reset_i && !flush_i && d0_valid_i && !hz0;
  assign issue1_o  = issue0_o && d1_valid_i && !hz1;
  assign stall_D_o = reset_i && !flush_i && d0_valid_i && !issue0_o;
  assign split_D_o = issue0_o && d1_valid_i && !issue1_o;
  assign stall_F_o = stall_D_o || split_D_o;

  always_comb begin
    cnt_d    = cnt_q;
    uf_d     = uf_q;
    inc      = 1'b0;
    sum      = '0;
    dec      = '0;
    cnt_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc = (issue0_o && d0_writes_i && d0_rd_i == REG_AW'(r)) ||
            (issue1_o && d1_writes_i && d1_rd_i == REG_AW'(r));
      dec = '0;
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_en_i[k] && wb_rd_i[k*REG_AW +: REG_AW] == REG_AW'(r))
          dec = dec + SUM_W'(1);
      end
      sum = SUM_W'(cnt_q[r]) + SUM_W'(inc);
      if (dec > sum) begin
        cnt_d[r] = '0;
        uf_d     = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(sum - dec);
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_D_o && stall_q != {STALL_W{1'b1}})
      stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      stall_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      uf_q    <= uf_d;
    end
  end

  assign stall_cycles_o  = stall_q;
  assign underflow_err_o = uf_q;

endmodule

// File: tb/tb_issue_scoreboard_n.sv
module tb_issue_scoreboard_n;
  localparam int NR = 32, AW = 5, WP = 2, CW = 2, SW = 32;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, flush;
  logic d0_valid, d0_rs1_en, d0_rs2_en, d0_writes;
  logic d1_valid, d1_rs1_en, d1_rs2_en, d1_writes;
  logic [AW-1:0] d0_rs1, d0_rs2, d0_rd, d1_rs1, d1_rs2, d1_rd;
  logic [WP-1:0] wb_en;
  logic [WP*AW-1:0] wb_rd;
  logic issue0, issue1, stall_F, stall_D, split_D, underflow_err;
  logic [SW-1:0] stall_cycles;

  issue_scoreboard_n #(.NUM_REGS(NR), .REG_AW(AW), .WB_PORTS(WP), .CNT_W(CW), .STALL_W(SW)) dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush),
    .d0_valid_i(d0_valid), .d0_rs1_i(d0_rs1), .d0_rs2_i(d0_rs2), .d0_rd_i(d0_rd),
    .d0_rs1_en_i(d0_rs1_en), .d0_rs2_en_i(d0_rs2_en), .d0_writes_i(d0_writes),
    .d1_valid_i(d1_valid), .d1_rs1_i(d1_rs1), .d1_rs2_i(d1_rs2), .d1_rd_i(d1_rd),
    .d1_rs1_en_i(d1_rs1_en), .d1_rs2_en_i(d1_rs2_en), .d1_writes_i(d1_writes),
    .wb_en_i(wb_en), .wb_rd_i(wb_rd),
    .issue0_o(issue0), .issue1_o(issue1), .stall_F_o(stall_F), .stall_D_o(stall_D),
    .split_D_o(split_D), .stall_cycles_o(stall_cycles), .underflow_err_o(underflow_err));

  // Reference model: outstanding writes per register as plain integers.
  int pend [NR];
  longint stall_m;
  bit uf_m;
  int checks = 0, errors = 0;

  function automatic bit pending(int r);
    return r != 0 && pend[r] > 0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic b0(bit v, int rs1, int rs2, int rd, bit e1, bit e2, bit w);
    d0_valid = v; d0_rs1 = AW'(rs1); d0_rs2 = AW'(rs2); d0_rd = AW'(rd);
    d0_rs1_en = e1; d0_rs2_en = e2; d0_writes = w;
  endtask

  task automatic b1(bit v, int rs1, int rs2, int rd, bit e1, bit e2, bit w);
    d1_valid = v; d1_rs1 = AW'(rs1); d1_rs2 = AW'(rs2); d1_rd = AW'(rd);
    d1_rs1_en = e1; d1_rs2_en = e2; d1_writes = w;
  endtask

  task automatic wb(bit e0, int r0, bit e1, int r1);
    wb_en = {e1, e0};
    wb_rd = {AW'(r1), AW'(r0)};
  endtask

  // One clock: predict outputs from the model, compare, then advance the
  // model by the rules for this edge. x0/x1 >= 0 add a directed expectation.
  task automatic cycle(int x0 = -1, int x1 = -1);
    bit h0, h1, e0, e1, sd, sp;
    int inc, dec;
    #1;
    h0 = (d0_rs1_en && pending(int'(d0_rs1))) || (d0_rs2_en && pending(int'(d0_rs2))) ||
         (d0_writes && d0_rd != 0 && pend[d0_rd] == CMAX);
    h1 = (d1_rs1_en && pending(int'(d1_rs1))) || (d1_rs2_en && pending(int'(d1_rs2))) ||
         (d1_writes && d1_rd != 0 && pend[d1_rd] == CMAX) ||
         (d0_writes && d0_rd != 0 && ((d1_rs1_en && d1_rs1 == d0_rd) ||
          (d1_rs2_en && d1_rs2 == d0_rd) || (d1_writes && d1_rd == d0_rd)));
    e0 = reset && !flush && d0_valid && !h0;
    e1 = e0 && d1_valid && !h1;
    sd = reset && !flush && d0_valid && !e0;
    sp = e0 && d1_valid && !e1;
    chk("issue0", 64'(issue0), 64'(e0));
    chk("issue1", 64'(issue1), 64'(e1));
    chk("stall_D", 64'(stall_D), 64'(sd));
    chk("split_D", 64'(split_D), 64'(sp));
    chk("stall_F", 64'(stall_F), 64'(sd || sp));
    chk("stall_cycles", 64'(stall_cycles), 64'(stall_m));
    chk("underflow_err", 64'(underflow_err), 64'(uf_m));
    if (x0 >= 0) chk("dir_issue0", 64'(issue0), 64'(x0));
    if (x1 >= 0) chk("dir_issue1", 64'(issue1), 64'(x1));
    @(posedge clk);
    if (!reset) begin
      foreach (pend[r]) pend[r] = 0;
      stall_m = 0;
      uf_m = 0;
    end else begin
      for (int r = 1; r < NR; r++) begin
        inc = int'(e0 && d0_writes && d0_rd == r) + int'(e1 && d1_writes && d1_rd == r);
        dec = 0;
        for (int k = 0; k < WP; k++)
          if (wb_en[k] && wb_rd[k*AW +: AW] == r) dec++;
        if (dec > pend[r] + inc) begin
          pend[r] = 0;
          uf_m = 1;
        end else begin
          pend[r] = pend[r] + inc - dec;
        end
      end
      if (sd && stall_m < 64'hFFFF_FFFF) stall_m++;
    end
    #1;
  endtask

  initial begin
    foreach (pend[r]) pend[r] = 0;
    stall_m = 0; uf_m = 0;
    reset = 0; flush = 0;
    b0(1, 2, 3, 1, 1, 1, 1); b1(1, 5, 6, 4, 1, 1, 1); wb(0, 0, 0, 0);
    cycle(0, 0); cycle(0, 0);
    reset = 1;
    // Independent pair issues together.
    cycle(1, 1);
    // Make x5 pending, then a reader of x5 with rs2 disabled on x0.
    b1(0, 0, 0, 0, 0, 0, 0); b0(1, 0, 0, 5, 1, 0, 1);
    cycle(1, 0);
    b0(1, 5, 0, 7, 1, 0, 1);
    cycle(0, 0);
    wb(1, 5, 0, 0); cycle(0, 0);
    wb(0, 0, 0, 0); cycle(1, 0);
    b0(0, 0, 0, 0, 0, 0, 0);
    wb(1, 1, 1, 4); cycle();
    wb(1, 7, 0, 0); cycle();
    wb(0, 0, 0, 0);
    // Intra-bundle RAW: split, then shifted slot stalls on x8.
    b0(1, 0, 0, 8, 1, 0, 1); b1(1, 8, 8, 9, 1, 1, 1);
    cycle(1, 0);
    b0(1, 8, 8, 9, 1, 1, 1); b1(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0);
    wb(1, 8, 0, 0); cycle(0, 0);
    wb(0, 0, 0, 0); cycle(1, 0);
    b0(0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 1, 9); cycle();
    wb(0, 0, 0, 0);
    // WAW up to the counter maximum.
    b0(1, 0, 0, 10, 0, 0, 1);
    cycle(1, 0); cycle(1, 0); cycle(1, 0);
    cycle(0, 0);
    wb(1, 10, 1, 10); cycle(0, 0);
    wb(0, 0, 0, 0); cycle(1, 0);
    b0(0, 0, 0, 0, 0, 0, 0);
    wb(1, 10, 1, 10); cycle();
    wb(0, 0, 0, 0); cycle();
    // Flush suppresses issue; underflow is sticky.
    flush = 1;
    b0(1, 1, 2, 3, 1, 1, 1); b1(1, 4, 5, 6, 1, 1, 1);
    cycle(0, 0);
    flush = 0;
    b0(0, 0, 0, 0, 0, 0, 0); b1(0, 0, 0, 0, 0, 0, 0);
    cycle();
    wb(1, 3, 0, 0); cycle();
    wb(0, 0, 0, 0); cycle(); cycle();
    // Build pending state, reset with a coincident write-back.
    b0(1, 0, 0, 2, 0, 0, 1); b1(1, 0, 0, 5, 0, 0, 1);
    cycle(1, 1);
    b1(0, 0, 0, 0, 0, 0, 0); cycle(1, 0);
    b0(0, 0, 0, 0, 0, 0, 0);
    reset = 0; wb(1, 2, 1, 5); cycle();
    reset = 1; wb(0, 0, 0, 0);
    b0(1, 2, 5, 3, 1, 1, 1); cycle(1, 0);
    b0(0, 0, 0, 0, 0, 0, 0); cycle();

    // Randomised traffic on a small register window to force collisions.
    for (int i = 0; i < 600; i++) begin
      int r0, r1;
      reset = ($urandom_range(79) != 0);
      flush = ($urandom_range(9) == 0);
      b0($urandom_range(3) != 0, $urandom_range(7), $urandom_range(7), $urandom_range(7),
         $urandom_range(1), $urandom_range(1), $urandom_range(1));
      b1($urandom_range(1), $urandom_range(7), $urandom_range(7), $urandom_range(7),
         $urandom_range(1), $urandom_range(1), $urandom_range(1));
      r0 = $urandom_range(7);
      r1 = $urandom_range(7);
      wb(pend[r0] > 0 ? $urandom_range(1) == 1 : $urandom_range(15) == 0, r0,
         pend[r1] > 0 ? $urandom_range(1) == 1 : $urandom_range(15) == 0, r1);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
